mem_port_arbiter: RTL

Two-requester arbiter and sequencer for a single unified memory port, so instruction fetch and data load/store share one memory. The arbiter sits between the program-counter/fetch path, the load/store path (ALU result as address, read_data2 as store data), and the memory. It issues one transaction at a time, times the fixed memory latency, and routes the response back to its owner. Data requests normally win; a starvation counter guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_arb_pick.sv | 21 ++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam int DEF_MEM_LATENCY  = 1;
    localparam int DEF_STARVE_LIMIT = 4;
    // Wide enough for the largest legal latency of 15.
    localparam int CNT_W            = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the unified memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational priority pick: data first, unless fetch has been starved too long.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          if_req,
    input  logic          d_req,
    input  logic [SW-1:0] starve_cnt,
    output logic          grant_if,
    output logic          grant_d
);

    logic starved;

    assign starved  = (starve_cnt == SW'(STARVE_LIMIT));
    assign grant_if = if_req & (~d_req | starved);
    assign grant_d  = d_req & ~grant_if;

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: grants fetch or data access to one memory,
// times the fixed read latency and returns the response to its owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | nothing outstanding; grant one pending request
    // WAIT  | latency timer running; capture response when cnt hits 1

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              owner_q;
    logic              store_q;
    logic [SW-1:0]     starve_q;
    logic              if_rvalid_q, d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              grant_if, grant_d;
    logic              issue, capture;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .starve_cnt (starve_q),
        .grant_if   (grant_if),
        .grant_d    (grant_d)
    );

    always_comb begin
        state_d       = state_q;
        issue         = 1'b0;
        capture       = 1'b0;
        bus.if_gnt    = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    issue         = 1'b1;
                    bus.d_gnt     = 1'b1;
                    bus.mem_req   = 1'b1;
                    bus.mem_we    = bus.d_we;
                    bus.mem_addr  = bus.d_addr;
                    bus.mem_wdata = bus.d_wdata;
                    state_d       = WAIT;
                end else if (grant_if) begin
                    issue        = 1'b1;
                    bus.if_gnt   = 1'b1;
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = bus.if_addr;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                bus.busy = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_IF;
            store_q     <= 1'b0;
            starve_q    <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if (issue) begin
                cnt_q   <= CNT_W'(MEM_LATENCY);
                owner_q <= grant_d ? OWN_D : OWN_IF;
                store_q <= grant_d & bus.d_we;
                // Count consecutive data wins only while fetch is actually waiting.
                if (grant_d && bus.if_req)
                    starve_q <= (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
                else
                    starve_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (capture) begin
                if (owner_q == OWN_D) begin
                    d_rvalid_q <= 1'b1;
                    d_rdata_q  <= store_q ? '0 : bus.mem_rdata;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule
